// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port 64-bit data SRAM between the
// pipeline MEM stage (cpu_*) and the external load/debug port (ext_*).
// CPU has default priority; after EXT_MAX_WAIT consecutive denials the
// external port is forced through for one grant. Reads are tagged so the
// returning data is steered to the requester that issued them.
// Optional build macro: DMEM_ARB_PERF_EN adds perf_cpu_stalls/perf_ext_grants.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned EXT_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_cpu_stalls,
    output logic [31:0]       perf_ext_grants
`endif
);

    typedef enum logic {
        CPU_PRIO,
        EXT_PRIO
    } state_e;

    localparam logic [3:0] WAIT_MAX  = 4'(EXT_MAX_WAIT);
    localparam logic [3:0] WAIT_LAST = 4'(EXT_MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic              rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_granted;
    logic              ext_granted;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= CPU_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: forced priority after the last tolerated denial, held for one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CPU_PRIO: begin
                if (ext_req && !ext_gnt && (wait_cnt_q == WAIT_LAST)) begin
                    state_d = EXT_PRIO;
                end
            end
            EXT_PRIO: begin
                if (ext_gnt || !ext_req) begin
                    state_d = CPU_PRIO;
                end
            end
            default: state_d = CPU_PRIO;
        endcase
    end

    // Outputs: single grant per cycle and memory port mux; nothing is granted while in reset
    always_comb begin
        cpu_granted = 1'b0;
        ext_granted = 1'b0;
        if (arst_n) begin
            unique case (state_q)
                CPU_PRIO: begin
                    cpu_granted = cpu_req;
                    ext_granted = ext_req & ~cpu_req;
                end
                EXT_PRIO: begin
                    ext_granted = ext_req;
                    cpu_granted = cpu_req & ~ext_req;
                end
                default: ;
            endcase
        end
        cpu_stall = cpu_req & ~cpu_granted & arst_n;
        ext_gnt   = ext_granted;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        if (cpu_granted) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_ren   = ~cpu_wen;
            mem_wen   = cpu_wen;
        end else if (ext_granted) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_ren   = ~ext_wen;
            mem_wen   = ext_wen;
        end
    end

    // Wait counter and read-return tagging; return data passes straight through
    // on the valid cycle and the hold register keeps it afterwards
    always_comb begin
        if (ext_req && !ext_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = '0;
        end
        rd_pending_d = mem_ren;
        rd_owner_d   = ext_granted;
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        if (rd_pending_q && !rd_owner_q) begin
            cpu_rdata_d = mem_rdata;
        end
        if (rd_pending_q && rd_owner_q) begin
            ext_rdata_d = mem_rdata;
        end
        cpu_rvalid = rd_pending_q & ~rd_owner_q;
        ext_rvalid = rd_pending_q & rd_owner_q;
        cpu_rdata  = cpu_rdata_d;
        ext_rdata  = ext_rdata_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stalls_q, perf_cpu_stalls_d;
    logic [31:0] perf_ext_grants_q, perf_ext_grants_d;

    // Performance counters: free-running, wrap at 2^32
    always_comb begin
        perf_cpu_stalls_d = perf_cpu_stalls_q + {31'd0, cpu_stall};
        perf_ext_grants_d = perf_ext_grants_q + {31'd0, ext_gnt};
        perf_cpu_stalls   = perf_cpu_stalls_q;
        perf_ext_grants   = perf_ext_grants_q;
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_cpu_stalls_q <= '0;
            perf_ext_grants_q <= '0;
        end else begin
            perf_cpu_stalls_q <= perf_cpu_stalls_d;
            perf_ext_grants_q <= perf_ext_grants_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_dmem_port_arbiter;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned MAXW = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          cpu_req, cpu_wen, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_wen, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   perf_cpu_stalls, perf_ext_grants;
`endif

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .EXT_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_cpu_stalls(perf_cpu_stalls), .perf_ext_grants(perf_ext_grants)
`endif
    );

    always #5 clk = ~clk;

    // Single-port SRAM stub with registered read
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
    end

    task automatic drive_cpu(input logic req, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_wen = wen; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_ext(input logic req, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ext_req = req; ext_wen = wen; ext_addr = a; ext_wdata = d;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        drive_cpu(1'b1, 1'b1, 64'h40, 64'h1111);
        drive_ext(1'b1, 1'b0, 64'h48, '0);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid, mem_ren, mem_wen} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/gnt/crv/erv/ren/wen=%b want 000000",
                     {cpu_stall, ext_gnt, cpu_rvalid, ext_rvalid, mem_ren, mem_wen});
        end
        checks++;
        if ({cpu_rdata, ext_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got crd=%h erd=%h maddr=%h mwd=%h want all 0",
                     cpu_rdata, ext_rdata, mem_addr, mem_wdata);
        end
`ifdef DMEM_ARB_PERF_EN
        checks++;
        if ({perf_cpu_stalls, perf_ext_grants} !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_cpu_stalls, perf_ext_grants);
        end
`endif
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_cpu_write_read();
        @(negedge clk);
        drive_cpu(1'b1, 1'b1, 64'h10, 64'hDEAD);
        #1;
        checks++;
        if ({cpu_stall, mem_wen, mem_ren, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b0, 64'h10, 64'hDEAD}) begin
            errors++;
            $display("FAIL cpu_wr: got stall=%b wen=%b ren=%b addr=%h wd=%h want 0 1 0 10 dead",
                     cpu_stall, mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        @(negedge clk);
        drive_cpu(1'b1, 1'b0, 64'h10, '0);
        #1;
        checks++;
        if ({cpu_stall, mem_ren, mem_wen, mem_addr} !== {1'b0, 1'b1, 1'b0, 64'h10}) begin
            errors++;
            $display("FAIL cpu_rd: got stall=%b ren=%b wen=%b addr=%h want 0 1 0 10",
                     cpu_stall, mem_ren, mem_wen, mem_addr);
        end
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {1'b1, 1'b0, 64'hDEAD}) begin
            errors++;
            $display("FAIL cpu_ret: got crv=%b erv=%b crd=%h want 1 0 dead", cpu_rvalid, ext_rvalid, cpu_rdata);
        end
        checks++;
        if ({mem_ren, mem_wen, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL idle_mem: got ren=%b wen=%b addr=%h wd=%h want all 0", mem_ren, mem_wen, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_ext_read();
        @(negedge clk);
        drive_ext(1'b1, 1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0);
        #1;
        checks++;
        if ({ext_gnt, mem_wen, mem_addr} !== {1'b1, 1'b1, 64'h20}) begin
            errors++;
            $display("FAIL ext_wr: got gnt=%b wen=%b addr=%h want 1 1 20", ext_gnt, mem_wen, mem_addr);
        end
        @(negedge clk);
        drive_ext(1'b1, 1'b0, 64'h20, '0);
        #1;
        checks++;
        if ({ext_gnt, mem_ren, cpu_stall} !== 3'b110) begin
            errors++;
            $display("FAIL ext_rd: got gnt=%b ren=%b stall=%b want 1 1 0", ext_gnt, mem_ren, cpu_stall);
        end
        @(negedge clk);
        drive_ext(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({ext_rvalid, cpu_rvalid, ext_rdata} !== {1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0}) begin
            errors++;
            $display("FAIL ext_ret: got erv=%b crv=%b erd=%h want 1 0 123456789abcdef0", ext_rvalid, cpu_rvalid, ext_rdata);
        end
    endtask

    task automatic test_forced_grant();
        logic [31:0] s0 = '0, e0 = '0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 1; c <= int'(MAXW) + 1; c++) begin
                @(negedge clk);
                drive_cpu(1'b1, 1'b0, 64'h10, '0);
                drive_ext(1'b1, 1'b0, 64'h20, '0);
                #1;
`ifdef DMEM_ARB_PERF_EN
                if (rep == 0 && c == 1) begin
                    s0 = perf_cpu_stalls;
                    e0 = perf_ext_grants;
                end
`endif
                checks++;
                if (c <= int'(MAXW)) begin
                    if ({ext_gnt, cpu_stall, mem_addr} !== {1'b0, 1'b0, 64'h10}) begin
                        errors++;
                        $display("FAIL forced_wait r%0d c%0d: got gnt=%b stall=%b addr=%h want 0 0 10",
                                 rep, c, ext_gnt, cpu_stall, mem_addr);
                    end
                end else begin
                    if ({ext_gnt, cpu_stall, mem_addr} !== {1'b1, 1'b1, 64'h20}) begin
                        errors++;
                        $display("FAIL forced_gnt r%0d: got gnt=%b stall=%b addr=%h want 1 1 20",
                                 rep, ext_gnt, cpu_stall, mem_addr);
                    end
                end
            end
        end
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({ext_rvalid, cpu_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL forced_ret: got erv=%b crv=%b want 1 0", ext_rvalid, cpu_rvalid);
        end
`ifdef DMEM_ARB_PERF_EN
        checks++;
        if ({perf_cpu_stalls - s0, perf_ext_grants - e0} !== {32'd2, 32'd2}) begin
            errors++;
            $display("FAIL perf_delta: got stalls+%0d grants+%0d want +2 +2",
                     perf_cpu_stalls - s0, perf_ext_grants - e0);
        end
`else
        if (s0 != e0) $display("note: perf counters not built");
`endif
    endtask

    task automatic test_alternating();
        @(negedge clk); drive_cpu(1'b1, 1'b1, 64'h08, 64'hAAAA_0008);
        @(negedge clk); drive_cpu(1'b1, 1'b1, 64'h18, 64'hBBBB_0018);
        @(negedge clk);
        drive_cpu(1'b1, 1'b0, 64'h08, '0);
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b1, 1'b0, 64'h18, '0);
        #1;
        checks++;
        if ({ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata} !== {1'b1, 1'b1, 1'b0, 64'hAAAA_0008}) begin
            errors++;
            $display("FAIL alt_n1: got gnt=%b crv=%b erv=%b crd=%h want 1 1 0 aaaa0008",
                     ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata);
        end
        @(negedge clk);
        drive_ext(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({ext_rvalid, cpu_rvalid, ext_rdata, cpu_rdata} !== {1'b1, 1'b0, 64'hBBBB_0018, 64'hAAAA_0008}) begin
            errors++;
            $display("FAIL alt_n2: got erv=%b crv=%b erd=%h crd=%h want 1 0 bbbb0018 aaaa0008",
                     ext_rvalid, cpu_rvalid, ext_rdata, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_cpu(1'b1, 1'b0, 64'h10, '0);
            drive_ext(1'b1, 1'b0, 64'h28, '0);
        end
        #1;
        checks++;
        if ({cpu_stall, ext_gnt, mem_ren} !== 3'b001) begin
            errors++;
            $display("FAIL mid_pre: got stall=%b gnt=%b ren=%b want 0 0 1", cpu_stall, ext_gnt, mem_ren);
        end
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, mem_ren, mem_wen, mem_addr} !== '0) begin
            errors++;
            $display("FAIL mid_rst: got crv=%b erv=%b crd=%h erd=%h ren=%b wen=%b addr=%h want all 0",
                     cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, mem_ren, mem_wen, mem_addr);
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_post: got crv=%b erv=%b want 0 0", cpu_rvalid, ext_rvalid);
        end
        // wait counter must restart from zero: full MAXW denials again
        for (int c = 1; c <= int'(MAXW) + 1; c++) begin
            @(negedge clk);
            drive_cpu(1'b1, 1'b0, 64'h10, '0);
            drive_ext(1'b1, 1'b0, 64'h28, '0);
            #1;
            checks++;
            if (ext_gnt !== (c == int'(MAXW) + 1)) begin
                errors++;
                $display("FAIL mid_wait c%0d: got gnt=%b want %b", c, ext_gnt, (c == int'(MAXW) + 1));
            end
        end
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        logic [DW-1:0] gold [256];
        int unsigned   denied = 0;
        bit            hold_ext = 0;
        bit            pend_v = 0, pend_ext = 0;
        logic [DW-1:0] pend_data = '0, cpu_hold = '0, ext_hold = '0;
        logic [31:0]   exp_stalls = '0, exp_grants = '0;
        bit            cw, ew, e_ren, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 256; i++) gold[i] = sram[i];
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            drive_cpu(($urandom_range(0, 3) != 0), 1'($urandom), 64'($urandom_range(0, 15)) << 3,
                      {$urandom, $urandom});
            if (!hold_ext)
                drive_ext(($urandom_range(0, 2) != 0), 1'($urandom), 64'($urandom_range(0, 15)) << 3,
                          {$urandom, $urandom});
            #1;
            ew = ext_req && (!cpu_req || denied >= MAXW);
            cw = cpu_req && !ew;
            e_addr = '0; e_wd = '0; e_ren = 0; e_wen = 0;
            if (cw) begin
                e_addr = cpu_addr; e_wd = cpu_wdata; e_ren = !cpu_wen; e_wen = cpu_wen;
            end else if (ew) begin
                e_addr = ext_addr; e_wd = ext_wdata; e_ren = !ext_wen; e_wen = ext_wen;
            end
            if (pend_v && !pend_ext) cpu_hold = pend_data;
            if (pend_v && pend_ext)  ext_hold = pend_data;
            checks++;
            if ({cpu_stall, ext_gnt} !== {cpu_req && !cw, ew}) begin
                errors++;
                $display("FAIL rnd_gnt cyc%0d: got stall=%b gnt=%b want %b %b", cyc, cpu_stall, ext_gnt, cpu_req && !cw, ew);
            end
            checks++;
            if ({mem_ren, mem_wen, mem_addr, mem_wdata} !== {e_ren, e_wen, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rnd_mem cyc%0d: got ren=%b wen=%b addr=%h wd=%h want %b %b %h %h",
                         cyc, mem_ren, mem_wen, mem_addr, mem_wdata, e_ren, e_wen, e_addr, e_wd);
            end
            checks++;
            if ({cpu_rvalid, cpu_rdata} !== {pend_v && !pend_ext, cpu_hold}) begin
                errors++;
                $display("FAIL rnd_cpu_ret cyc%0d: got rv=%b rd=%h want %b %h", cyc, cpu_rvalid, cpu_rdata, pend_v && !pend_ext, cpu_hold);
            end
            checks++;
            if ({ext_rvalid, ext_rdata} !== {pend_v && pend_ext, ext_hold}) begin
                errors++;
                $display("FAIL rnd_ext_ret cyc%0d: got rv=%b rd=%h want %b %h", cyc, ext_rvalid, ext_rdata, pend_v && pend_ext, ext_hold);
            end
            // advance the model to the next cycle
            if (cpu_req && !cw) exp_stalls++;
            if (ew) exp_grants++;
            denied   = (ext_req && !ew) ? denied + 1 : 0;
            hold_ext = ext_req && !ew;
            pend_v   = e_ren;
            pend_ext = ew;
            if (e_ren) pend_data = gold[e_addr[7:0]];
            if (e_wen) gold[e_addr[7:0]] = e_wd;
        end
`ifdef DMEM_ARB_PERF_EN
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({perf_cpu_stalls, perf_ext_grants} !== {exp_stalls, exp_grants}) begin
            errors++;
            $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_cpu_stalls, perf_ext_grants, exp_stalls, exp_grants);
        end
`else
        if (exp_stalls == 32'hFFFF_FFFF && exp_grants == 32'hFFFF_FFFF) $display("note: counters saturated");
`endif
        @(negedge clk);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_ext(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_write_read();
        test_ext_read();
        test_forced_grant();
        test_alternating();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 64-bit data SRAM between two requesters: the pipeline MEM stage (cpu_*) and the external load/debug port (ext_*).
- Sits between the EX/MEM pipeline register outputs and the data memory's internal port.
- CPU has default priority. A bounded-wait counter guarantees the external port a grant; while the external port holds the memory, the pipeline is stalled.
- Tags every read so that return data is steered to the requester that issued it.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
DATA_W, 64, data width
EXT_MAX_WAIT, 4, number of consecutive denied ext cycles after which ext is forced through (range 1..15)

Ports:
clk  in  1  main clock
arst_n  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage access request (mem_read or mem_write)
cpu_wen  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU denied this cycle; pipeline must hold
cpu_rdata  out  DATA_W  read data, valid the cycle after a granted CPU read
cpu_rvalid  out  1  cpu_rdata valid
ext_req  in  1  external access request; held with addr/data until ext_gnt
ext_wen  in  1  1 = write, 0 = read
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  external access accepted this cycle
ext_rdata  out  DATA_W  external read data
ext_rvalid  out  1  ext_rdata valid, one cycle after a granted ext read
mem_addr  out  ADDR_W  to SRAM
mem_wen  out  1  to SRAM
mem_ren  out  1  to SRAM
mem_wdata  out  DATA_W  to SRAM
mem_rdata  in  DATA_W  from SRAM; registered read, 1-cycle latency

Behaviour:
- FSM with two states.
  - CPU_PRIO is the reset state.
  - EXT_PRIO is entered on the clock edge where wait_cnt == EXT_MAX_WAIT-1 and ext is denied again. It returns to CPU_PRIO on the edge after ext_gnt.
- Grant is combinational, at most one grant per cycle:
  - CPU_PRIO: cpu_req wins. ext is granted only if !cpu_req.
  - EXT_PRIO: ext_req wins. If ext_req has dropped, grant cpu and return to CPU_PRIO.
- cpu_stall = cpu_req & ~cpu_granted.
- ext_gnt = ext_req & ext_granted.
- mem_* is muxed from the granted requester.
  - mem_ren = granted & ~wen.
  - mem_wen = granted & wen.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_ren = 0, mem_wen = 0.
- wait_cnt (4 bits):
  - +1 each cycle ext_req & ~ext_gnt, saturating at EXT_MAX_WAIT.
  - Cleared on ext_gnt or when ext_req is low.
- Read-return tag: registers rd_owner (0 = cpu, 1 = ext) and rd_pending on every granted read.
  - Next cycle: mem_rdata goes to the owner's rdata, and that owner's rvalid = 1.
  - The other owner's rdata holds its last value; its rvalid = 0.
- Back-to-back reads from alternating owners are legal. Each return is independently tagged.
- Simultaneous cpu and ext write to the same address: only the granted one is performed. The other retries next cycle.
- Reset (async, any time):
  - State = CPU_PRIO, wait_cnt = 0, rd_pending = 0.
  - cpu_rvalid = ext_rvalid = 0; cpu_rdata = ext_rdata = 0.
  - All mem_* = 0.
  - An in-flight read is discarded; no rvalid is produced after reset release.
- Latency: 0 cycles request-to-grant; 1 cycle grant-to-read-data.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_cpu_stalls[31:0] and perf_ext_grants[31:0].
  - Free-running counters, reset to 0, wrapping at 2^32.
  - perf_cpu_stalls increments on each cycle with cpu_stall = 1.
  - perf_ext_grants increments on each ext_gnt.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- CPU write addr 0x10 data 0xDEAD, then CPU read 0x10 with ext idle -> cpu_stall = 0 throughout; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEAD.
- ext_req read 0x20 with cpu_req low -> ext_gnt in the same cycle; ext_rvalid one cycle later with the SRAM contents; cpu_rvalid stays 0.
- cpu_req held high continuously, ext_req held, EXT_MAX_WAIT = 4 -> ext denied for 4 cycles; in the 5th cycle ext_gnt = 1 and cpu_stall = 1; FSM back in CPU_PRIO on the next cycle.
- Alternating grants: CPU read 0x08 at cycle n, ext read 0x18 at n+1 -> cpu_rvalid at n+1 and ext_rvalid at n+2, each with its own address's data; no cross-delivery.
- arst_n pulsed low mid-read (grant at n, reset between n and n+1) -> no rvalid at n+1; all outputs 0; wait_cnt = 0.
- With DMEM_ARB_PERF_EN: scenario 3 repeated twice -> perf_ext_grants = 2, perf_cpu_stalls = 2.
